mul_iter_unit: RTL
==================

Name: mul_iter_unit

Overview:
- Multi-cycle iterative multiplier in the EX stage, directly downstream of the ALU control decode.
- Consumes ALU control code 4'b0011 (mult) together with the two EX operands.
- Computes the product by shift-add over several cycles and stalls the pipeline until the result is ready.
- All other ALU codes bypass this block and use the single-cycle ALU path.

Parameters:
- WIDTH, 32, operand and result width in bits; must be even and at least 4.
- MUL_CODE, 4'b0011, ALUCtrl value that selects multiply.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-low reset.
- start_i  input  1  EX-stage instruction valid (not a bubble).
- ALUCtrl_i  input  4  ALU control code from the ALU control decode.
- src1_i  input  WIDTH  multiplicand (rs value after forwarding).
- src2_i  input  WIDTH  multiplier (rt value after forwarding).
- flush_i  input  1  synchronous abort of the in-flight multiply (branch flush).
- stall_o  output  1  freeze PC, IF/ID and ID/EX; hold EX.
- done_o  output  1  one-cycle pulse; result_o valid this cycle.
- result_o  output  WIDTH  low WIDTH bits of src1*src2.

Behaviour:
- Reset (rst_i=0, asynchronous, any state): state=IDLE, counter=0, result_o=0, done_o=0, stall_o=0, internal accumulator/shift registers=0.
- States: IDLE, BUSY, DONE.
- accept = start_i & (ALUCtrl_i==MUL_CODE) & (state is IDLE or DONE) & ~flush_i.
- IDLE: on accept edge, latch src1 into multiplicand reg, src2 into multiplier reg, clear accumulator, counter=0, go BUSY.
- BUSY, one iteration per edge:
  - If multiplier LSB=1, add multiplicand into accumulator (mod 2^WIDTH).
  - Shift multiplicand left 1; shift multiplier right 1 (logical); counter+1.
  - After WIDTH iterations, go DONE and load result_o with the accumulator.
- DONE: done_o=1 for exactly this one cycle.
  - An accept here starts a new multiply (DONE->BUSY, back-to-back allowed).
  - Otherwise DONE->IDLE.
- Latency: done_o is high in the cycle after the WIDTH-th BUSY edge, i.e. WIDTH cycles after the accept edge (32 by default).
- Fixed latency; no early-out for zero or small operands.
- stall_o (combinational) = accept_in_IDLE | (state==BUSY) | (state==DONE & accept).
  - stall_o is 0 in the DONE cycle without a new accept, so EX/MEM captures result_o.
- Operands are two's complement. The low WIDTH bits are identical for signed and unsigned, so the multiply itself is unsigned.
- src1_i/src2_i/ALUCtrl_i changes during BUSY are ignored; operands were latched at accept.
- flush_i=1 in any state:
  - Next state IDLE, counter=0, done_o=0.
  - result_o keeps its previous value.
  - flush_i wins over a simultaneous accept.
- Non-mult ALUCtrl_i in IDLE: no state change, stall_o=0.
- result_o holds its value until the next DONE load or reset.
- Counter width: clog2(WIDTH)+1 bits.

Optional Feature:
- Macro MUL_RADIX4_EN.
- Defined: retire two multiplier bits per BUSY edge.
  - Add 0, 1x, 2x or 3x multiplicand, selected by the two multiplier LSBs; 3x is precomputed at accept.
  - Shift by 2.
  - WIDTH/2 BUSY edges; done_o high WIDTH/2 cycles after accept (16 by default).
  - stall_o window shrinks to match.
- Undefined: radix-2 as specified above, latency WIDTH.
- result_o values are identical in both builds.

Test Plan:
- Reset, then accept src1=7, src2=6 -> stall_o=1 for 32 cycles; done_o pulses at cycle 32 after the accept edge with result_o=42; stall_o=0 in the done cycle.
- src1=32'hFFFFFFFD (-3), src2=5 -> result_o=32'hFFFFFFF1 (-15).
- src1=32'h80000000, src2=2 -> result_o=0 (wrap); then src1=32'h0001_0001, src2=32'h0000_FFFF -> 32'hFFFF_FFFF.
- Accept 9*9; assert flush_i at BUSY iteration 10 -> IDLE next cycle, no done_o, result_o unchanged; a new accept 3*4 -> 12 after full latency.
- Accept 5*5; pull rst_i low mid-BUSY, asynchronously -> immediately state IDLE, result_o=0, stall_o=0; after release, ALUCtrl_i=4'b0010 with start_i=1 -> stall_o=0, no done_o.
- Back-to-back: accept 2*3 and, in its DONE cycle, accept 4*5 -> done_o with 6, then stall continues and a second done_o with 20. With MUL_RADIX4_EN, the same pair completes at 16-cycle spacing.

Source files
------------

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier for the EX stage: low WIDTH bits of src1*src2 with a fixed latency.
// Build option MUL_RADIX4_EN retires two multiplier bits per cycle and halves the latency.
module mul_iter_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [3:0] MUL_CODE = 4'b0011
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

`ifdef MUL_RADIX4_EN
  localparam int ITERS = WIDTH / 2;
`else
  localparam int ITERS = WIDTH;
`endif
  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] acc_sum_s;
  logic             accept_s;
`ifdef MUL_RADIX4_EN
  logic [WIDTH-1:0] mcand3_q, mcand3_d;
`endif

  // Reset also masks the accept so the pipeline is never stalled while held in reset.
  assign accept_s = rst_i & start_i & (ALUCtrl_i == MUL_CODE) & ~flush_i &
                    ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign stall_o  = accept_s | (state_q == ST_BUSY);
  assign done_o   = done_q;
  assign result_o = result_q;

  // Partial product selected by the low multiplier bit(s).
  always_comb begin
    addend_s = {WIDTH{1'b0}};
`ifdef MUL_RADIX4_EN
    case (mplier_q[1:0])
      2'b00:   addend_s = {WIDTH{1'b0}};
      2'b01:   addend_s = mcand_q;
      2'b10:   addend_s = {mcand_q[WIDTH-2:0], 1'b0};
      2'b11:   addend_s = mcand3_q;
      default: addend_s = {WIDTH{1'b0}};
    endcase
`else
    if (mplier_q[0]) begin
      addend_s = mcand_q;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
`endif
    acc_sum_s = acc_q + addend_s;
  end

  // Next-state logic: accept, iterate, retire; flush overrides everything but the result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
`ifdef MUL_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    if (flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            state_d  = ST_BUSY;
            cnt_d    = {CNT_W{1'b0}};
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = {WIDTH{1'b0}};
`ifdef MUL_RADIX4_EN
            mcand3_d = src1_i + {src1_i[WIDTH-2:0], 1'b0};
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_BUSY: begin
          acc_d = acc_sum_s;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef MUL_RADIX4_EN
          mcand_d  = {mcand_q[WIDTH-3:0], 2'b00};
          mcand3_d = {mcand3_q[WIDTH-3:0], 2'b00};
          mplier_d = {2'b00, mplier_q[WIDTH-1:2]};
`else
          mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
`endif
          if (cnt_q == LAST_CNT) begin
            state_d  = ST_DONE;
            result_d = acc_sum_s;
            done_d   = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      done_q   <= 1'b0;
`ifdef MUL_RADIX4_EN
      mcand3_q <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef MUL_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

endmodule
